// File: rtl/free_list_pkg.sv
// Shared pipeline constants for physical register renaming, plus the
// free-list operation encoding used to steer pointer/count updates.
package free_list_pkg;

  localparam int unsigned PR_W      = 6;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned NUM_PR    = 64;
  localparam int unsigned FL_DEPTH  = NUM_PR - ARCH_REGS;

  typedef enum logic [2:0] {
    FL_IDLE,
    FL_ALLOC,
    FL_RETIRE,
    FL_ALLOC_RETIRE,
    FL_UNPOP
  } fl_op_e;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical register numbers: pops at head for dispatch,
// pushes at tail on retire, and pushes back at head during ROB recovery.
module free_list #(
  parameter int unsigned PR_W  = free_list_pkg::PR_W,
  parameter int unsigned DEPTH = free_list_pkg::FL_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_req,
  input  logic            hazard_stall,
  output logic [PR_W-1:0] PR_new,
  output logic            alloc_ok,
  output logic            empty,
  output logic            full,
  input  logic            retire_en,
  input  logic            RegDest_retire,
  input  logic [PR_W-1:0] PR_old_RT,
  input  logic            recover,
  input  logic            RegDest_out,
  input  logic [PR_W-1:0] PR_new_flush
);
  import free_list_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PR_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             alloc, ret_req, unpop_req, ret, unpop;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [PR_W-1:0]  wr_data;
  fl_op_e           op;

  assign PR_new   = mem_q[head_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign alloc    = alloc_req && !empty && !recover && !hazard_stall;
  assign alloc_ok = alloc;

  assign ret_req   = retire_en && RegDest_retire && !recover;
  assign unpop_req = recover && RegDest_out;
  // Pushes into a full list are dropped so the count can never exceed DEPTH.
  assign ret       = ret_req && !full;
  assign unpop     = unpop_req && !full;

  always_comb begin
    op = FL_IDLE;
    if (unpop)             op = FL_UNPOP;
    else if (alloc && ret) op = FL_ALLOC_RETIRE;
    else if (alloc)        op = FL_ALLOC;
    else if (ret)          op = FL_RETIRE;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = tail_q;
    wr_data = PR_old_RT;
    unique case (op)
      FL_ALLOC: begin
        head_d  = head_q + PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
      FL_RETIRE: begin
        wr_en   = 1'b1;
        tail_d  = tail_q + PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end
      FL_ALLOC_RETIRE: begin
        wr_en  = 1'b1;
        head_d = head_q + PTR_W'(1);
        tail_d = tail_q + PTR_W'(1);
      end
      FL_UNPOP: begin
        // Squashed PRs return youngest-first, rebuilding allocation order.
        wr_en   = 1'b1;
        wr_addr = head_q - PTR_W'(1);
        wr_data = PR_new_flush;
        head_d  = head_q - PTR_W'(1);
        count_d = count_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(DEPTH);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PR_W'(DEPTH + i);
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst) !((ret_req || unpop_req) && full)
  );

endmodule

// File: tb/tb_free_list.sv
// Directed vector bench for free_list: reset image, drain, retire-from-empty,
// alloc+retire, recovery unpop, wrap-around and asynchronous reset.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_req = 1'b0, hazard_stall = 1'b0;
  logic [5:0] PR_new;
  logic       alloc_ok, empty, full;
  logic       retire_en = 1'b0, RegDest_retire = 1'b0;
  logic [5:0] PR_old_RT = '0;
  logic       recover = 1'b0, RegDest_out = 1'b0;
  logic [5:0] PR_new_flush = '0;

  int checks = 0;
  int errors = 0;

  free_list #(.PR_W(6), .DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .hazard_stall(hazard_stall),
    .PR_new(PR_new), .alloc_ok(alloc_ok), .empty(empty), .full(full),
    .retire_en(retire_en), .RegDest_retire(RegDest_retire), .PR_old_RT(PR_old_RT),
    .recover(recover), .RegDest_out(RegDest_out), .PR_new_flush(PR_new_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a, h, re, rr;
    logic [5:0] po;
    logic       rc, ro;
    logic [5:0] pf;
    logic [5:0] epr;
    logic       eok, eem, efu;
  } vec_t;

  function automatic vec_t mk(input logic a, h, re, rr, input logic [5:0] po,
                              input logic rc, ro, input logic [5:0] pf,
                              input logic [5:0] epr, input logic eok, eem, efu);
    vec_t v;
    v.a = a; v.h = h; v.re = re; v.rr = rr; v.po = po;
    v.rc = rc; v.ro = ro; v.pf = pf;
    v.epr = epr; v.eok = eok; v.eem = eem; v.efu = efu;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    alloc_req = v.a; hazard_stall = v.h;
    retire_en = v.re; RegDest_retire = v.rr; PR_old_RT = v.po;
    recover = v.rc; RegDest_out = v.ro; PR_new_flush = v.pf;
    #1;
    chk({tag, ".PR_new"},   {2'b0, PR_new}, {2'b0, v.epr});
    chk({tag, ".alloc_ok"}, {7'b0, alloc_ok}, {7'b0, v.eok});
    chk({tag, ".empty"},    {7'b0, empty},    {7'b0, v.eem});
    chk({tag, ".full"},     {7'b0, full},     {7'b0, v.efu});
  endtask

  task automatic do_reset();
    @(negedge clk);
    alloc_req = 1'b0; retire_en = 1'b0; recover = 1'b0; hazard_stall = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t seq[$];

    // Drain, retire-from-empty, and alloc+retire at count 10.
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 32,0,0,1));
    for (int i = 0; i < 32; i++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 6'(32+i),1,0,(i==0)));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 32,0,1,0));
    tbl.push_back(mk(0,0,1,1,5,0,0,0, 32,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 5,1,0,0));
    tbl.push_back(mk(1,0,1,1,6,0,0,0, 33,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 6,0,0,0));
    for (int j = 0; j < 9; j++)
      tbl.push_back(mk(0,0,1,1,6'(10+j),0,0,0, 6,0,0,0));
    tbl.push_back(mk(1,0,1,1,7,0,0,0, 6,1,0,0));
    for (int j = 0; j < 9; j++)
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 6'(10+j),1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 7,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 44,0,1,0));

    repeat (2) @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) step(tbl[i], $sformatf("A%0d", i));

    // Recovery: unpop 34 then 33, ignored alloc/retire during recover.
    do_reset();
    seq.push_back(mk(0,0,0,0,0,0,0,0,  32,0,0,1));
    seq.push_back(mk(1,0,0,0,0,0,0,0,  32,1,0,1));
    seq.push_back(mk(1,0,0,0,0,0,0,0,  33,1,0,0));
    seq.push_back(mk(1,0,0,0,0,0,0,0,  34,1,0,0));
    seq.push_back(mk(1,0,1,1,9,1,1,34, 35,0,0,0));
    seq.push_back(mk(1,0,1,1,9,1,1,33, 34,0,0,0));
    seq.push_back(mk(1,0,1,1,9,1,0,0,  33,0,0,0));
    seq.push_back(mk(0,0,0,0,0,0,0,0,  33,0,0,0));
    seq.push_back(mk(0,0,1,1,9,0,0,0,  33,0,0,0));
    seq.push_back(mk(1,1,0,0,0,0,0,0,  33,0,0,1));
    seq.push_back(mk(1,0,0,0,0,0,0,0,  33,1,0,1));
    seq.push_back(mk(0,0,0,0,0,0,0,0,  34,0,0,0));
    foreach (seq[i]) step(seq[i], $sformatf("B%0d", i));

    // Wrap-around: 40 alloc/retire pairs at count 31.
    do_reset();
    step(mk(1,0,0,0,0,0,0,0, 32,1,0,1), "C_first");
    for (int k = 0; k < 40; k++)
      step(mk(1,0,1,1,6'(k),0,0,0, (k < 31) ? 6'(33+k) : 6'(k-31),1,0,0),
           $sformatf("C%0d", k));
    step(mk(1,0,0,0,0,0,0,0, 9,1,0,0), "C_tail");

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    alloc_req = 1'b0; retire_en = 1'b0; RegDest_retire = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst.PR_new",   {2'b0, PR_new}, 8'd32);
    chk("async_rst.full",     {7'b0, full},     8'd1);
    chk("async_rst.empty",    {7'b0, empty},    8'd0);
    chk("async_rst.alloc_ok", {7'b0, alloc_ok}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    step(mk(1,0,0,0,0,0,0,0, 32,1,0,1), "post_rst0");
    step(mk(0,0,0,0,0,0,0,0, 33,0,0,0), "post_rst1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
